// File: rtl/ether.sv
// RMII-style receive framer: locks onto preamble+SFD and forwards payload words
// with one cycle of latency until carrier drops.
module ether #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] rxd,
    input  logic         crsdv,
    output logic         axiov,
    output logic [N-1:0] axiod
);
    localparam int PRE_LEN = 64 / N - 1;
    localparam int CW      = $clog2(PRE_LEN + 1);

    // Built by loop so N=2 avoids a zero-width replication for the SFD.
    function automatic logic [N-1:0] mk_pre();
        logic [N-1:0] p;
        p = '0;
        for (int i = 0; i < N / 2; i++) p[2*i +: 2] = 2'b01;
        return p;
    endfunction

    function automatic logic [N-1:0] mk_sfd();
        logic [N-1:0] p;
        p = mk_pre();
        p[N-1 -: 2] = 2'b11;
        return p;
    endfunction

    localparam logic [N-1:0]  PRE     = mk_pre();
    localparam logic [N-1:0]  SFD     = mk_sfd();
    localparam logic [CW-1:0] PRE_CNT = CW'(PRE_LEN);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_ERR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          axiov_q;
    logic [N-1:0]  axiod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
        end else if (!crsdv) begin
            // Carrier loss aborts whatever was in progress.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            axiov_q <= 1'b0;
        end else begin
            axiov_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rxd == PRE) begin
                        state_q <= S_PRE;
                        cnt_q   <= CW'(1);
                    end else begin
                        state_q <= S_ERR;
                    end
                end
                S_PRE: begin
                    if (cnt_q < PRE_CNT) begin
                        if (rxd == PRE) cnt_q <= cnt_q + CW'(1);
                        else            state_q <= S_ERR;
                    end else if (rxd == SFD) begin
                        state_q <= S_DATA;
                    end else begin
                        state_q <= S_ERR;
                    end
                end
                S_DATA: begin
                    axiov_q <= 1'b1;
                    axiod_q <= rxd;
                end
                default: state_q <= S_ERR;
            endcase
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;
endmodule

// File: tb/tb_ether.sv
// Directed bench for ether at N=4: framing, error paths, carrier drop and reset.
module tb_ether;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rxd = 4'b0000;
    logic       crsdv = 1'b0;
    logic       axiov;
    logic [3:0] axiod;

    int passed = 0;
    int total  = 0;
    logic hi;  // sticky OR of axiov over a stretch of cycles

    localparam logic [3:0] PRE = 4'b0101;
    localparam logic [3:0] SFD = 4'b1101;

    ether #(.N(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .crsdv(crsdv),
        .axiov(axiov),
        .axiod(axiod)
    );

    always #5 clk = ~clk;

    // Apply one word, clock it in, and settle past the edge.
    task automatic step(input logic c, input logic [3:0] d);
        crsdv = c;
        rxd   = d;
        @(posedge clk);
        #1;
        hi = hi | axiov;
    endtask

    task automatic send_hdr(input int npre, input logic [3:0] sfd);
        for (int i = 0; i < npre; i++) step(1'b1, PRE);
        step(1'b1, sfd);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b1, 4'b1010);
        total++;
        if (axiov !== 1'b0 || axiod !== 4'b0000) begin
            $display("FAIL reset: axiov=%b axiod=%b expected 0/0000", axiov, axiod);
        end else passed++;
        rst = 1'b0;
        hi = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, PRE);
        total++;
        if (hi !== 1'b0) $display("FAIL idle: axiov rose=%b expected 0", hi);
        else passed++;
    endtask

    task automatic test_valid_frame;
        logic [3:0] w;
        hi = 1'b0;
        send_hdr(15, SFD);
        total++;
        if (hi !== 1'b0) $display("FAIL valid_hdr: axiov rose=%b expected 0 (SFD must not appear)", hi);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            w = (i % 2 == 0) ? 4'b1010 : 4'b0101;
            step(1'b1, w);
            total++;
            if (axiov !== 1'b1 || axiod !== w)
                $display("FAIL valid_payload[%0d]: axiov=%b axiod=%b expected 1/%b", i, axiov, axiod, w);
            else passed++;
        end
        step(1'b0, 4'b1111);
        total++;
        if (axiov !== 1'b0 || axiod !== 4'b0101)
            $display("FAIL valid_end: axiov=%b axiod=%b expected 0/0101", axiov, axiod);
        else passed++;
    endtask

    task automatic test_corrupt_pre;
        hi = 1'b0;
        for (int i = 0; i < 13; i++) step(1'b1, PRE);
        step(1'b1, 4'b0000);
        step(1'b1, SFD);
        step(1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1100);
            step(1'b1, 4'b0101);
        end
        total++;
        if (hi !== 1'b0) $display("FAIL corrupt_pre: axiov rose=%b expected 0", hi);
        else passed++;
        step(1'b0, 4'b0000);
    endtask

    task automatic test_corrupt_sfd;
        hi = 1'b0;
        send_hdr(15, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1011);
            step(1'b1, 4'b0111);
        end
        total++;
        if (hi !== 1'b0) $display("FAIL corrupt_sfd: axiov rose=%b expected 0", hi);
        else passed++;
        step(1'b0, 4'b0000);
    endtask

    task automatic test_crsdv_drop;
        send_hdr(15, SFD);
        step(1'b1, 4'b0011);
        total++;
        if (axiov !== 1'b1 || axiod !== 4'b0011)
            $display("FAIL drop_pre: axiov=%b axiod=%b expected 1/0011", axiov, axiod);
        else passed++;
        step(1'b0, 4'b1001);
        total++;
        if (axiov !== 1'b0) $display("FAIL drop_edge: axiov=%b expected 0", axiov);
        else passed++;
        // Valid-looking framing with carrier low must be ignored.
        hi = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, PRE);
        step(1'b0, SFD);
        step(1'b0, 4'b1010);
        // Carrier back mid-payload without preamble lands in ERROR.
        step(1'b1, 4'b1010);
        step(1'b1, 4'b0101);
        step(1'b1, 4'b1101);
        total++;
        if (hi !== 1'b0) $display("FAIL drop_after: axiov rose=%b expected 0", hi);
        else passed++;
        step(1'b0, 4'b0000);
    endtask

    task automatic test_overrun;
        hi = 1'b0;
        send_hdr(16, SFD);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0110);
        total++;
        if (hi !== 1'b0) $display("FAIL overrun: axiov rose=%b expected 0", hi);
        else passed++;
        step(1'b0, 4'b0000);
        send_hdr(15, SFD);
        step(1'b1, 4'b1110);
        total++;
        if (axiov !== 1'b1 || axiod !== 4'b1110)
            $display("FAIL overrun_recover: axiov=%b axiod=%b expected 1/1110", axiov, axiod);
        else passed++;
        step(1'b0, 4'b0000);
    endtask

    task automatic test_rst_mid;
        send_hdr(15, SFD);
        step(1'b1, 4'b1010);
        step(1'b1, 4'b0111);
        total++;
        if (axiov !== 1'b1 || axiod !== 4'b0111)
            $display("FAIL rst_pre: axiov=%b axiod=%b expected 1/0111", axiov, axiod);
        else passed++;
        rst = 1'b1;
        step(1'b1, 4'b1010);
        rst = 1'b0;
        total++;
        if (axiov !== 1'b0 || axiod !== 4'b0000)
            $display("FAIL rst_mid: axiov=%b axiod=%b expected 0/0000", axiov, axiod);
        else passed++;
        hi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b1010);
            step(1'b1, 4'b0101);
        end
        total++;
        if (hi !== 1'b0) $display("FAIL rst_rest: axiov rose=%b expected 0", hi);
        else passed++;
        step(1'b0, 4'b0000);
    endtask

    task automatic test_back_to_back;
        send_hdr(15, SFD);
        step(1'b1, 4'b0001);
        step(1'b0, 4'b0000);
        send_hdr(15, SFD);
        step(1'b1, 4'b1000);
        total++;
        if (axiov !== 1'b1 || axiod !== 4'b1000)
            $display("FAIL back_to_back: axiov=%b axiod=%b expected 1/1000", axiov, axiod);
        else passed++;
        step(1'b0, 4'b0000);
    endtask

    initial begin
        hi = 1'b0;
        #1;
        test_reset();
        test_valid_frame();
        test_corrupt_pre();
        test_corrupt_sfd();
        test_crsdv_drop();
        test_overrun();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ether.md
ETHER -- requirements
Module: ether

Interface
REQ-001 Parameter N, default 4, receive word width in bits; legal values 2 and 4.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rxd  input  N  received data word from the PHY; bit 0 is the earliest bit on the wire.
REQ-005 crsdv  input  1  carrier-sense/data-valid; high while a frame is on the wire.
REQ-006 axiov  output  1  payload-valid strobe; registered.
REQ-007 axiod  output  N  payload word; registered.

Function
REQ-008 Constants: PRE = N/2 copies of 2'b01 (4'b0101 at N=4); SFD = 2'b11 above N/2-1 copies of 2'b01 (4'b1101 at N=4, 2'b11 at N=2); PRE_LEN = 64/N - 1 (15 at N=4).
REQ-009 A valid frame is exactly PRE_LEN consecutive PRE words, then one SFD word, then payload words, all with crsdv high.
REQ-010 The block implements four states: IDLE, PREAMBLE, DATA, ERROR, plus a preamble word counter wide enough for PRE_LEN.
REQ-011 IDLE: crsdv high and rxd==PRE -> PREAMBLE with count=1; crsdv high and rxd!=PRE -> ERROR; crsdv low -> stay.
REQ-012 PREAMBLE, count<PRE_LEN: rxd==PRE -> count+1; any other word -> ERROR.
REQ-013 PREAMBLE, count==PRE_LEN: rxd==SFD -> DATA; any other word, including an extra PRE, -> ERROR.
REQ-014 DATA: each rising edge with crsdv high loads axiod<=rxd and sets axiov<=1, giving exactly one cycle of latency from rxd to axiod.
REQ-015 The SFD word is never presented on axiod; the first word after SFD is the first payload word.
REQ-016 ERROR: stay in ERROR until crsdv is sampled low; axiov stays 0 throughout.
REQ-017 In every state, crsdv sampled low -> IDLE, count cleared, axiov<=0 on that edge.
REQ-018 axiov is 1 only for words captured in DATA with crsdv high; in all other cycles axiov=0.
REQ-019 axiod holds its last value whenever axiov=0.
REQ-020 axiod content is don't-care while axiov=0.
REQ-021 No frame length limit and no FCS checking; payload passes through until crsdv drops.
REQ-022 Re-acquisition needs crsdv low for at least one sampled cycle followed by a fresh preamble.

Reset
REQ-023 rst high at a rising edge: state<=IDLE, count<=0, axiov<=0, axiod<=0; rst takes priority over all other inputs.
REQ-024 Reset asserted mid-frame aborts the frame; the block needs crsdv low then a full new preamble+SFD before axiov rises again.

Verification
REQ-025 Valid frame: crsdv=1, 15x 4'b0101, 4'b1101, then alternating 4'b1010/4'b0101 -> from the edge after the first payload word, axiov=1 and axiod equals the previous cycle's rxd (1010, 0101, ...).
REQ-026 Corrupt preamble: 13x 0101, 0000, 1101, 1111, 1100/0101 pattern -> axiov=0 for the whole frame.
REQ-027 Corrupt SFD: 15x 0101, then 1010 instead of 1101, then 1011/0111 -> axiov=0 for the whole frame.
REQ-028 crsdv=0 during payload (including data that matches a valid preamble/SFD with crsdv low) -> axiov=0 on the next edge and stays 0.
REQ-029 Preamble overrun: 16x 0101 then 1101 -> ERROR state, axiov=0 until crsdv drops; a following valid frame is then received normally.
REQ-030 rst pulsed for one cycle mid-payload -> axiov=0 and axiod=0 on the next edge; the remaining payload is ignored.
